// File: rtl/clock_divider_pkg.sv
// Shared types and constants for the programmable clock divider.
// Optional period counter is enabled with the PERIOD_COUNT_EN macro.
package clock_divider_pkg;

    localparam int DEF_CNT_W = 32;
    localparam int MIN_DIV   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/divider_counter.sv
// Period counter for the programmable clock divider: cnt register,
// wrap/tick detect and the registered duty-cycle compare for clk_out.
module divider_counter
    import clock_divider_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_i,
    input  logic             run_nxt_i,
    input  logic [CNT_W-1:0] div_i,
    input  logic [CNT_W-1:0] high_nxt_i,
    output logic             tick_o,
    output logic             clk_out_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             clk_out_q;
    logic             clk_out_d;
    logic [CNT_W-1:0] div_m1;

    // active div is never below 2, so this cannot underflow
    assign div_m1    = div_i - CNT_W'(1);
    assign tick_o    = run_i && (cnt_q == div_m1);
    assign clk_out_o = clk_out_q;

    // next count and the duty compare against the high-time in force next cycle
    always_comb begin
        cnt_d = '0;
        if (run_i && run_nxt_i && !tick_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        clk_out_d = run_nxt_i && (cnt_d < high_nxt_i);
    end

    // counter and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
        end
    end

endmodule

// File: rtl/programmable_clock_divider.sv
// Programmable clock divider: IDLE/RUN control, load handshake, shadow pair.
// Define PERIOD_COUNT_EN to add the 16-bit period_count output.
module programmable_clock_divider
    import clock_divider_pkg::*;
#(
    parameter int          CNT_W        = DEF_CNT_W,
    parameter int unsigned DEFAULT_DIV  = 5000,
    parameter int unsigned DEFAULT_HIGH = 2500
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_in,
    input  logic [CNT_W-1:0] high_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             load_err,
    output logic             clk_out,
`ifdef PERIOD_COUNT_EN
    output logic [15:0]      period_count,
`endif
    output logic             tick
);

    localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] HIGH_RST = CNT_W'(DEFAULT_HIGH);
    localparam logic [CNT_W-1:0] DIV_MIN  = CNT_W'(MIN_DIV);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] div_d;
    logic [CNT_W-1:0] high_q;
    logic [CNT_W-1:0] high_d;
    logic [CNT_W-1:0] sdiv_q;
    logic [CNT_W-1:0] sdiv_d;
    logic [CNT_W-1:0] shigh_q;
    logic [CNT_W-1:0] shigh_d;
    logic             pend_q;
    logic             pend_d;
    logic             err_q;
    logic             err_d;
    logic             hs;
    logic             bad;
    logic             apply;
    logic             wrap;

    assign load_ready = !pend_q;
    assign load_err   = err_q;
    assign tick       = wrap;

    // run control: en alone decides IDLE/RUN, leaving RUN never completes the period
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (en) state_d = RUN;
            RUN:  if (!en) state_d = IDLE;
        endcase
    end

    // handshake, rejection and period-boundary apply of the shadow pair
    always_comb begin
        hs      = load_valid && !pend_q;
        bad     = div_in < DIV_MIN;
        apply   = pend_q && ((state_q == IDLE) || wrap);
        div_d   = apply ? sdiv_q : div_q;
        high_d  = apply ? shigh_q : high_q;
        sdiv_d  = sdiv_q;
        shigh_d = shigh_q;
        pend_d  = pend_q && !apply;
        err_d   = hs && bad;
        if (hs && !bad) begin
            sdiv_d  = div_in;
            shigh_d = high_in;
            pend_d  = 1'b1;
        end
    end

    // control and configuration registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            div_q   <= DIV_RST;
            high_q  <= HIGH_RST;
            sdiv_q  <= DIV_RST;
            shigh_q <= HIGH_RST;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            high_q  <= high_d;
            sdiv_q  <= sdiv_d;
            shigh_q <= shigh_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    divider_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .run_i      (state_q == RUN),
        .run_nxt_i  (state_d == RUN),
        .div_i      (div_q),
        .high_nxt_i (high_d),
        .tick_o     (wrap),
        .clk_out_o  (clk_out)
    );

`ifdef PERIOD_COUNT_EN
    logic [15:0] pc_q;
    logic [15:0] pc_d;

    assign period_count = pc_q;

    // a new pair restarts the count, otherwise count completed periods
    always_comb begin
        pc_d = pc_q;
        if (apply) begin
            pc_d = '0;
        end else if (wrap) begin
            pc_d = pc_q + 16'd1;
        end
    end

    // period counter register
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end
`endif

endmodule
